// File: rtl/slength_if.sv
// Length-encoder bus: match length in, bit-reversed Huffman field and bit count out.
//   match_length_in     9  LZ77 match length (legal 3..258)
//   slength_data_out   13  packed code+extra bits, LSB first, upper bits zero
//   slength_valid_bits  4  number of valid bits in slength_data_out
interface slength_if;
    logic [8:0]  match_length_in;
    logic [12:0] slength_data_out;
    logic [3:0]  slength_valid_bits;

    modport master (
        output match_length_in,
        input  slength_data_out,
        input  slength_valid_bits
    );

    modport slave (
        input  match_length_in,
        output slength_data_out,
        output slength_valid_bits
    );
endinterface

// File: rtl/slength.sv
// Static DEFLATE length encoder: match length -> fixed-Huffman length symbol
// plus extra bits, emitted bit-reversed (first-transmitted bit in bit 0).
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears both outputs
//   bus    slength_if.slave: match_length_in in; slength_data_out,
//          slength_valid_bits out (registered, one cycle latency)
module slength (
    input  logic       clk,
    input  logic       rst_n,
    slength_if.slave   bus
);
    localparam int unsigned LEN_W  = 9;
    localparam int unsigned DATA_W = 13;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned NSYM   = 29;

    // Base length of symbols 257..285, index = symbol - 257.
    localparam logic [LEN_W-1:0] BASE [NSYM] = '{
        9'd3,   9'd4,   9'd5,   9'd6,   9'd7,   9'd8,   9'd9,   9'd10,
        9'd11,  9'd13,  9'd15,  9'd17,  9'd19,  9'd23,  9'd27,  9'd31,
        9'd35,  9'd43,  9'd51,  9'd59,  9'd67,  9'd83,  9'd99,  9'd115,
        9'd131, 9'd163, 9'd195, 9'd227, 9'd258
    };

    logic [LEN_W-1:0]  len_eff;
    logic [4:0]        idx;
    logic [2:0]        ebits;
    logic [4:0]        extra;
    logic [7:0]        code;
    logic [CNT_W-1:0]  cbits;
    logic [DATA_W-1:0] v_c;
    logic [DATA_W-1:0] rev_c;
    logic [DATA_W-1:0] data_c;
    logic [CNT_W-1:0]  n_c;

    // Symbol lookup: largest base not exceeding the (clamped) length.
    always_comb begin
        len_eff = (bus.match_length_in < LEN_W'(3)) ? LEN_W'(3) : bus.match_length_in;
        idx     = '0;
        for (int unsigned i = 0; i < NSYM; i++) begin
            if (len_eff >= BASE[i]) idx = 5'(i);
        end
        // Groups of four symbols share an extra-bit count from index 8 on; 285 has none.
        if (idx < 5'd8 || idx == 5'd28) ebits = 3'd0;
        else                            ebits = 3'((idx - 5'd4) >> 2);
        extra = 5'(len_eff - BASE[idx]);
        if (idx <= 5'd22) begin
            code  = 8'(idx) + 8'd1;
            cbits = CNT_W'(7);
        end else begin
            code  = 8'(idx) + 8'd169;
            cbits = CNT_W'(8);
        end
    end

    // Field assembly and bit reversal within n bits.
    always_comb begin
        if (bus.match_length_in > LEN_W'(258)) begin
            v_c = DATA_W'(1);
            n_c = CNT_W'(8);
        end else begin
            v_c = (DATA_W'(code) << ebits) | DATA_W'(extra);
            n_c = cbits + CNT_W'(ebits);
        end
        for (int unsigned j = 0; j < DATA_W; j++) begin
            rev_c[j] = v_c[DATA_W-1-j];
        end
        // Field sits in the top n bits after full reversal; slide it down to bit 0.
        data_c = rev_c >> (CNT_W'(DATA_W) - n_c);
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.slength_data_out   <= '0;
            bus.slength_valid_bits <= '0;
        end else begin
            bus.slength_data_out   <= data_c;
            bus.slength_valid_bits <= n_c;
        end
    end
endmodule

// File: tb/tb_slength.sv
module tb_slength;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    slength_if bus();

    slength dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model from the DEFLATE length rules: group by power of two,
    // build the code+extra bit string MSB-first, transmit first bit at bit 0.
    function automatic void model(input int len, output logic [12:0] d, output int n);
        int sym, e, extra, c, code, off, pos;
        int l;
        d = '0;
        if (len > 258) begin
            d = 13'h080;
            n = 8;
            return;
        end
        l = (len < 3) ? 3 : len;
        e = 0;
        extra = 0;
        if (l == 258) begin
            sym = 285;
        end else if (l <= 10) begin
            sym = 254 + l;
        end else begin
            for (int k = 1; k <= 5; k++) begin
                if ((l - 3) >= (1 << (k + 2)) && (l - 3) < (1 << (k + 3))) e = k;
            end
            off   = l - 3 - (1 << (e + 2));
            extra = off % (1 << e);
            sym   = 265 + 4 * (e - 1) + off / (1 << e);
        end
        if (sym <= 279) begin
            c = 7;
            code = sym - 256;
        end else begin
            c = 8;
            code = sym - 280 + 192;
        end
        n = c + e;
        pos = 0;
        for (int b = c - 1; b >= 0; b--) begin
            d[pos] = ((code >> b) & 1) != 0;
            pos++;
        end
        for (int b = e - 1; b >= 0; b--) begin
            d[pos] = ((extra >> b) & 1) != 0;
            pos++;
        end
    endfunction

    task automatic apply(input int len);
        bus.match_length_in = 9'(len);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.match_length_in = 9'd100;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.slength_data_out !== 13'h000 || bus.slength_valid_bits !== 4'd0) begin
            $display("FAIL reset: data=%h bits=%0d, required 0000 0",
                     bus.slength_data_out, bus.slength_valid_bits);
            n_fail++;
        end
        rst_n = 1'b1;
        apply(3);
        n_checks++;
        if (bus.slength_data_out !== 13'h040 || bus.slength_valid_bits !== 4'd7) begin
            $display("FAIL first_after_reset: data=%h bits=%0d, required 0040 7",
                     bus.slength_data_out, bus.slength_valid_bits);
            n_fail++;
        end
    endtask

    task automatic test_directed;
        int          lens [11] = '{12, 11, 131, 257, 258, 259, 279, 479, 0, 1, 2};
        logic [12:0] exp_d [11] = '{13'h0C8, 13'h048, 13'h083, 13'h0F23, 13'h0A3,
                                    13'h080, 13'h080, 13'h080, 13'h040, 13'h040, 13'h040};
        int          exp_n [11] = '{8, 8, 13, 13, 8, 8, 8, 8, 7, 7, 7};
        for (int i = 0; i < 11; i++) begin
            apply(lens[i]);
            n_checks++;
            if (bus.slength_data_out !== exp_d[i] || int'(bus.slength_valid_bits) != exp_n[i]) begin
                $display("FAIL directed len=%0d: data=%h bits=%0d, required %h %0d", lens[i],
                         bus.slength_data_out, bus.slength_valid_bits, exp_d[i], exp_n[i]);
                n_fail++;
            end
        end
    endtask

    task automatic test_sweep;
        logic [12:0] ed;
        int          en;
        for (int len = 3; len <= 258; len++) begin
            apply(len);
            model(len, ed, en);
            n_checks++;
            if (bus.slength_data_out !== ed || int'(bus.slength_valid_bits) != en) begin
                $display("FAIL sweep len=%0d: data=%h bits=%0d, required %h %0d", len,
                         bus.slength_data_out, bus.slength_valid_bits, ed, en);
                n_fail++;
            end
        end
    endtask

    task automatic test_boundaries;
        int          pts [14] = '{10, 11, 18, 19, 34, 35, 66, 67, 114, 115, 130, 131, 257, 258};
        logic [12:0] ed;
        int          en;
        for (int i = 0; i < 14; i++) begin
            apply(pts[i]);
            model(pts[i], ed, en);
            n_checks++;
            if (bus.slength_data_out !== ed || int'(bus.slength_valid_bits) != en) begin
                $display("FAIL boundary len=%0d: data=%h bits=%0d, required %h %0d", pts[i],
                         bus.slength_data_out, bus.slength_valid_bits, ed, en);
                n_fail++;
            end
        end
    endtask

    // Random back-to-back: new input every cycle, checked one edge later.
    task automatic test_back_to_back;
        logic [12:0] ed;
        int          en;
        int          len;
        for (int i = 0; i < 300; i++) begin
            len = (i % 4 == 0) ? int'($urandom_range(511, 0)) : int'($urandom_range(258, 3));
            apply(len);
            model(len, ed, en);
            n_checks++;
            if (bus.slength_data_out !== ed || int'(bus.slength_valid_bits) != en) begin
                $display("FAIL random len=%0d: data=%h bits=%0d, required %h %0d", len,
                         bus.slength_data_out, bus.slength_valid_bits, ed, en);
                n_fail++;
            end
        end
    endtask

    task automatic test_reset_midstream;
        logic [12:0] ed;
        int          en;
        apply(200);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.slength_data_out !== 13'h000 || bus.slength_valid_bits !== 4'd0) begin
            $display("FAIL mid_reset: data=%h bits=%0d, required 0000 0",
                     bus.slength_data_out, bus.slength_valid_bits);
            n_fail++;
        end
        bus.match_length_in = 9'd67;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model(67, ed, en);
        n_checks++;
        if (bus.slength_data_out !== ed || int'(bus.slength_valid_bits) != en) begin
            $display("FAIL release_reencode: data=%h bits=%0d, required %h %0d",
                     bus.slength_data_out, bus.slength_valid_bits, ed, en);
            n_fail++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.match_length_in = '0;
        test_reset();
        test_directed();
        test_sweep();
        test_boundaries();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
